// File: rtl/des_subkey_sequencer.sv
// des_subkey_sequencer
// Sequential DES key schedule. A 64-bit key is loaded on an accepted start and
// the 16 round subkeys are then presented one per valid/ready handshake:
// K1..K16 (left rotations) for encryption, K16..K1 (right rotations) for
// decryption. Bit numbering is DES numbering: index 1 is DES bit 1.
//
// Ports:
//   clk           rising-edge clock
//   rst           asynchronous active-high reset
//   start         request a new schedule (accepted only while busy=0)
//   decrypt       direction, sampled with an accepted start (1 = K16 first)
//   key_in[64:1]  DES key bits 1..64 (bit 0 and parity bits ignored)
//   subkey_out    [48:1] current subkey, bit 0 tied to 0
//   subkey_valid  subkey_out and round_idx are valid
//   subkey_ready  consumer accepts the current subkey
//   round_idx     round number (1..16) of the subkey on subkey_out
//   busy          schedule in progress
//   done          one-cycle pulse after the 16th handshake
//
// Handshake: a subkey transfers on a rising edge where subkey_valid and
// subkey_ready are both high. While valid is high and ready is low,
// subkey_out and round_idx hold; valid never drops without a transfer
// (except on reset).
module des_subkey_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        decrypt,
  input  logic [64:0] key_in,
  output logic [48:0] subkey_out,
  output logic        subkey_valid,
  input  logic        subkey_ready,
  output logic [4:0]  round_idx,
  output logic        busy,
  output logic        done
);

  typedef enum logic {S_IDLE, S_EMIT} state_t;

  localparam logic [6:0] PC1_TAB [0:55] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

  localparam logic [5:0] PC2_TAB [0:47] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

  state_t      r_state, w_state_next;
  logic [1:28] r_c, r_d, w_c_next, w_d_next;
  logic        r_dec, w_dec_next;
  logic [4:0]  r_round, w_round_next;
  logic        r_done, w_done_next;
  logic [1:56] w_pc1;
  logic [1:56] w_cd;
  logic        w_unused_bits;

  // Parity bits and bit 0 never reach PC-1.
  assign w_unused_bits = ^{key_in[0], key_in[8], key_in[16], key_in[24],
                           key_in[32], key_in[40], key_in[48], key_in[56],
                           key_in[64]};

  // Shift amount of round r is 2 except for rounds 1, 2, 9 and 16.
  function automatic logic shift_two(input logic [4:0] r);
    return !(r == 5'd1 || r == 5'd2 || r == 5'd9 || r == 5'd16);
  endfunction

  // Packed [1:28] keeps DES bit 1 at the MSB, so a DES left rotation moves
  // bit 2 into position 1.
  function automatic logic [1:28] rot_l(input logic [1:28] x, input logic two);
    return two ? {x[3:28], x[1:2]} : {x[2:28], x[1]};
  endfunction

  function automatic logic [1:28] rot_r(input logic [1:28] x, input logic two);
    return two ? {x[27:28], x[1:26]} : {x[28], x[1:27]};
  endfunction

  always_comb begin
    w_pc1 = '0;
    for (int k = 0; k < 56; k++) w_pc1[k+1] = key_in[PC1_TAB[k]];
  end

  assign w_cd = {r_c, r_d};

  always_comb begin
    subkey_out = '0;
    for (int j = 0; j < 48; j++) subkey_out[j+1] = w_cd[PC2_TAB[j]];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_c     <= '0;
      r_d     <= '0;
      r_dec   <= 1'b0;
      r_round <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_c     <= w_c_next;
      r_d     <= w_d_next;
      r_dec   <= w_dec_next;
      r_round <= w_round_next;
      r_done  <= w_done_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_c_next     = r_c;
    w_d_next     = r_d;
    w_dec_next   = r_dec;
    w_round_next = r_round;
    w_done_next  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_dec_next   = decrypt;
          w_state_next = S_EMIT;
          if (decrypt) begin
            // Total shift over 16 rounds is 28, so C16/D16 equal C0/D0.
            w_c_next     = w_pc1[1:28];
            w_d_next     = w_pc1[29:56];
            w_round_next = 5'd16;
          end else begin
            w_c_next     = rot_l(w_pc1[1:28], 1'b0);
            w_d_next     = rot_l(w_pc1[29:56], 1'b0);
            w_round_next = 5'd1;
          end
        end
      end
      S_EMIT: begin
        if (subkey_ready) begin
          if (!r_dec) begin
            if (r_round == 5'd16) begin
              w_state_next = S_IDLE;
              w_done_next  = 1'b1;
            end else begin
              w_c_next     = rot_l(r_c, shift_two(r_round + 5'd1));
              w_d_next     = rot_l(r_d, shift_two(r_round + 5'd1));
              w_round_next = r_round + 5'd1;
            end
          end else begin
            // Undo this round's shift; on the final handshake (s(1)=1) this
            // returns C/D to PC1(key).
            w_c_next = rot_r(r_c, shift_two(r_round));
            w_d_next = rot_r(r_d, shift_two(r_round));
            if (r_round == 5'd1) begin
              w_state_next = S_IDLE;
              w_done_next  = 1'b1;
            end else begin
              w_round_next = r_round - 5'd1;
            end
          end
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  assign busy         = (r_state == S_EMIT);
  assign subkey_valid = (r_state == S_EMIT);
  assign round_idx    = r_round;
  assign done         = r_done;

endmodule

// File: tb/tb_des_subkey_sequencer.sv
// Testbench for des_subkey_sequencer: scoreboard of {round, subkey} entries
// generated from a reference key-schedule model, popped on each handshake.
module tb_des_subkey_sequencer;

  logic        clk = 1'b0;
  logic        rst, start, decrypt, subkey_ready;
  logic [64:0] key_in;
  logic [48:0] subkey_out;
  logic        subkey_valid, busy, done;
  logic [4:0]  round_idx;

  always #5 clk = ~clk;

  des_subkey_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .decrypt(decrypt), .key_in(key_in),
    .subkey_out(subkey_out), .subkey_valid(subkey_valid),
    .subkey_ready(subkey_ready), .round_idx(round_idx), .busy(busy), .done(done)
  );

  localparam logic [63:0] KEY  = 64'h133457799BBCDFF1;
  localparam logic [63:0] PAR  = 64'h0101010101010101;

  localparam int PC1_T [0:55] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
  localparam int PC2_T [0:47] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

  int n_checks = 0;
  int n_errors = 0;

  logic [52:0] exp_q[$];
  logic [47:0] model_ks [1:16];
  logic [55:0] model_cd0;
  logic [47:0] got_ks [1:16];
  logic        held = 1'b0;
  logic [52:0] held_val, mon_cur, mon_exp;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Hex notation has DES bit 1 at its MSB; the ports have DES bit i at index i.
  function automatic logic [64:0] to_des(input logic [63:0] h);
    logic [64:0] d;
    d = '0;
    for (int i = 1; i <= 64; i++) d[i] = h[64-i];
    return d;
  endfunction

  function automatic logic [47:0] sk_hex(input logic [48:0] s);
    logic [47:0] h;
    for (int j = 1; j <= 48; j++) h[48-j] = s[j];
    return h;
  endfunction

  // Reference schedule in hex-ordered vectors (MSB = DES bit 1).
  task automatic gen_model(input logic [63:0] key);
    logic [27:0] c, d;
    logic [55:0] cd;
    logic [47:0] ks;
    int sh;
    for (int k = 0; k < 56; k++) begin
      if (k < 28) c[27-k] = key[64-PC1_T[k]];
      else        d[55-k] = key[64-PC1_T[k]];
    end
    model_cd0 = {c, d};
    for (int r = 1; r <= 16; r++) begin
      sh = (r == 1 || r == 2 || r == 9 || r == 16) ? 1 : 2;
      for (int s = 0; s < sh; s++) begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end
      cd = {c, d};
      for (int j = 0; j < 48; j++) ks[47-j] = cd[56-PC2_T[j]];
      model_ks[r] = ks;
    end
  endtask

  task automatic push_exp(input logic dec);
    int r;
    for (int i = 0; i < 16; i++) begin
      r = dec ? 16 - i : i + 1;
      exp_q.push_back({5'(r), model_ks[r]});
    end
  endtask

  // Monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (!rst && subkey_valid) begin
      mon_cur = {round_idx, sk_hex(subkey_out)};
      if (held) chk("hold_stable", 64'(mon_cur), 64'(held_val));
      if (subkey_ready) begin
        held = 1'b0;
        chk("q_nonempty", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          mon_exp = exp_q.pop_front();
          chk("subkey", 64'(mon_cur), 64'(mon_exp));
        end
        if (round_idx >= 5'd1 && round_idx <= 5'd16) got_ks[round_idx] = mon_cur[47:0];
      end else begin
        held = 1'b1;
        held_val = mon_cur;
      end
    end else begin
      held = 1'b0;
    end
  end

  // Runs one schedule and returns at the falling edge of the done cycle.
  task automatic run_sched(input logic [63:0] key, input logic dec, input int pct,
                           input int inj, input logic [63:0] flip,
                           input logic now_start, output int cyc, output int stl);
    logic injected;
    gen_model(key);
    push_exp(dec);
    if (!now_start) begin
      @(posedge clk); #1;
    end
    start = 1'b1;
    decrypt = dec;
    key_in = to_des(key ^ flip);
    subkey_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    key_in = to_des({$urandom, $urandom});
    decrypt = ~dec;
    chk("busy_after_start", 64'(busy), 64'd1);
    chk("valid_after_start", 64'(subkey_valid), 64'd1);
    chk("first_round", 64'(round_idx), dec ? 64'd16 : 64'd1);
    cyc = 0;
    stl = 0;
    injected = 1'b0;
    while (cyc < 300) begin
      subkey_ready = (pct >= 100) || ($urandom_range(99) < pct);
      if (!injected && inj != 0 && round_idx == 5'(inj)) begin
        start = 1'b1;
        key_in = to_des(64'hFEDCBA9876543210);
        injected = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (done) break;
      cyc++;
      if (subkey_valid && !subkey_ready) stl++;
      @(posedge clk); #1;
    end
    chk("done_seen", 64'(done), 64'd1);
    chk("no_residue", 64'(exp_q.size()), 64'd0);
    chk("valid_in_done", 64'(subkey_valid), 64'd0);
    chk("busy_in_done", 64'(busy), 64'd0);
    chk("cycle_count", 64'(cyc), 64'(16 + stl));
  endtask

  task automatic chk_ref_keys(input string tag);
    chk({tag, "_K1"},  64'(got_ks[1]),  64'h1B02EFFC7072);
    chk({tag, "_K2"},  64'(got_ks[2]),  64'h79AED9DBC9E5);
    chk({tag, "_K15"}, 64'(got_ks[15]), 64'hBF918D3D3F0A);
    chk({tag, "_K16"}, 64'(got_ks[16]), 64'hCB3D8B0E17F5);
  endtask

  task automatic chk_done_one_cycle();
    @(posedge clk); #1;
    chk("done_one_cycle", 64'(done), 64'd0);
    chk("idle_after_done", 64'(busy), 64'd0);
  endtask

  initial begin
    int c, s, wait_cnt;
    logic [4:0] r_at_rst;
    rst = 1'b1;
    start = 1'b0;
    decrypt = 1'b0;
    key_in = '0;
    subkey_ready = 1'b0;
    #12;
    chk("rst_subkey", 64'(subkey_out), 64'd0);
    chk("rst_valid", 64'(subkey_valid), 64'd0);
    chk("rst_round", 64'(round_idx), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Encrypt, full throughput.
    run_sched(KEY, 1'b0, 100, 0, 64'd0, 1'b0, c, s);
    chk("enc_cycles", 64'(c), 64'd16);
    chk_ref_keys("enc");
    chk_done_one_cycle();

    // Decrypt, full throughput; C/D must be back at PC1(key).
    run_sched(KEY, 1'b1, 100, 0, 64'd0, 1'b0, c, s);
    chk_ref_keys("dec");
    chk("cd_restore", 64'({dut.r_c, dut.r_d}), 64'(model_cd0));
    chk_done_one_cycle();

    // Backpressure, ~30% ready.
    run_sched(KEY, 1'b0, 30, 0, 64'd0, 1'b0, c, s);
    chk_ref_keys("bp");
    chk("bp_stalls_seen", 64'(s > 0), 64'd1);

    // Parity bits flipped.
    run_sched(KEY, 1'b0, 100, 0, PAR, 1'b0, c, s);
    chk_ref_keys("parity");

    // Start during round 5 with another key, and during the final handshake.
    run_sched(KEY, 1'b0, 100, 5, 64'd0, 1'b0, c, s);
    chk_ref_keys("start_r5");
    run_sched(KEY, 1'b1, 60, 1, 64'd0, 1'b0, c, s);
    chk_done_one_cycle();

    // Asynchronous reset during round 9.
    gen_model(KEY);
    push_exp(1'b0);
    @(posedge clk); #1;
    start = 1'b1;
    decrypt = 1'b0;
    key_in = to_des(KEY);
    subkey_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_cnt = 0;
    r_at_rst = '0;
    while (wait_cnt < 100) begin
      @(negedge clk);
      r_at_rst = round_idx;
      if (round_idx == 5'd9) break;
      wait_cnt++;
    end
    chk("reached_r9", 64'(r_at_rst), 64'd9);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_subkey", 64'(subkey_out), 64'd0);
    chk("arst_valid", 64'(subkey_valid), 64'd0);
    chk("arst_round", 64'(round_idx), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_done", 64'(done), 64'd0);
    exp_q.delete();
    held = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("no_done_after_rst", 64'(done), 64'd0);
    end

    // Clean schedule after reset, then decrypt started in the done cycle.
    run_sched(KEY, 1'b0, 100, 0, 64'd0, 1'b0, c, s);
    chk_ref_keys("post_rst");
    run_sched(KEY, 1'b1, 100, 0, 64'd0, 1'b1, c, s);
    chk_ref_keys("b2b");
    chk_done_one_cycle();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/des_subkey_sequencer.md
Name: des_subkey_sequencer

Overview:
- Sequential DES key schedule. Loads a 64-bit key and emits the 16 round subkeys, one per handshake.
- Emits K1..K16 for encryption or K16..K1 for decryption, using left or right rotations of the C/D halves respectively.
- Sits between the key register and the round datapath, and feeds one 48-bit subkey per round.
- Bit numbering follows DES: index 1 is DES bit 1 (the MSB of the hex notation), and index 0 is unused.

Parameters:
- None. All widths are fixed by FIPS 46-3.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request a new schedule. Accepted only when busy=0.
- decrypt  in  1  sampled with an accepted start. 0 = K1 first; 1 = K16 first.
- key_in  in  65  [64:1] = DES key bits 1..64. Bit 0 and the parity bits 8,16,...,64 are ignored. Sampled only on an accepted start.
- subkey_out  out  49  [48:1] = current subkey Kr, bit 1 = DES bit 1. Bit 0 is tied to 0.
- subkey_valid  out  1  subkey_out and round_idx are valid.
- subkey_ready  in  1  consumer accepts the current subkey when valid&&ready.
- round_idx  out  5  round number r (1..16) of the subkey on subkey_out.
- busy  out  1  high from the cycle after start is accepted through the final handshake.
- done  out  1  one-cycle pulse in the cycle after the 16th handshake.

Behaviour:
- Reset values: all outputs 0; C, D, count and state cleared; state = IDLE. Reset asserted mid-schedule aborts immediately, with no done pulse.
- PC-1 (C = first 28 entries, D = last 28): 57 49 41 33 25 17 9 1 58 50 42 34 26 18 10 2 59 51 43 35 27 19 11 3 60 52 44 36 | 63 55 47 39 31 23 15 7 62 54 46 38 30 22 14 6 61 53 45 37 29 21 13 5 28 20 12 4.
- PC-2 over the 56-bit CD concatenation: 14 17 11 24 1 5 3 28 15 6 21 10 23 19 12 4 26 8 16 7 27 20 13 2 41 52 31 37 47 55 30 40 51 45 33 48 44 49 39 56 34 53 46 42 50 36 29 32.
- Shift schedule: s(r) = 1 for r = 1, 2, 9, 16; s(r) = 2 otherwise. Rotations apply to C and D independently, each 28 bits with wrap-around.
- States: IDLE, EMIT.
- IDLE:
  - busy=0, subkey_valid=0.
  - start=1 at edge t: C,D <= PC1(key_in).
  - Encrypt: C,D are additionally rotated left by s(1); round_idx <= 1.
  - Decrypt: no rotation (C16 = C0 because the total shift is 28); round_idx <= 16.
  - Go to EMIT. busy=1 and subkey_valid=1 from cycle t+1.
- EMIT:
  - subkey_out = PC2(C,D), derived combinationally from registered C/D; it is stable while valid&&!ready.
  - Handshake with r < 16 in encrypt mode: r <= r+1; C,D rotate left by s(r+1).
  - Handshake with r > 1 in decrypt mode: C,D rotate right by s(r), then r <= r-1.
  - Final handshake (r=16 encrypt, or r=1 decrypt): go to IDLE; done=1 for exactly the next cycle; busy=0 and subkey_valid=0 that same cycle.
  - Maximum throughput: one subkey per cycle; 16 cycles minimum per schedule.
- start while busy is ignored, including in the final handshake cycle.
- start in the done cycle is accepted normally, since the block is already IDLE.
- key_in and decrypt changes while busy have no effect.
- subkey_ready=0 holds all state indefinitely.
- After the final rotation in decrypt mode, C,D equal PC1(key); verification checks this internally via hierarchy.

Test Plan:
- Encrypt, key 0x133457799BBCDFF1, ready=1 always → subkey_valid for 16 consecutive cycles. Expected subkeys as hex over subkey_out[1:48]: K1=0x1B02EFFC7072, K2=0x79AED9DBC9E5, K15=0xBF918D3D3F0A, K16=0xCB3D8B0E17F5. round_idx runs 1..16, then done pulses once.
- Same key with decrypt=1 → first subkey 0xCB3D8B0E17F5 (round_idx=16), second 0xBF918D3D3F0A (15), last 0x1B02EFFC7072 (1). Output order is exactly the reverse of the encrypt run.
- Backpressure: random subkey_ready with 30% high → identical subkey sequence to the first test; subkey_out/round_idx held stable while valid&&!ready; total cycles = 16 + stall cycles.
- Robustness:
  - Flip only the parity bits of key_in → same subkeys as the first test.
  - start pulsed during round 5 with a different key → ignored, and the sequence continues unchanged.
- Reset: assert rst asynchronously mid-cycle during round 9 → all outputs go to 0 immediately, with no done pulse. The next start then runs a clean full schedule.
- Back-to-back: start asserted in the done cycle with decrypt=1 → accepted; K16 appears one cycle later.
